// File: rtl/clk_div_buff.sv
// clk_div_buff
//   Derives NCH independent, registered, glitch-free divided clocks from
//   master_clk. Each channel has a programmable ratio with a shadow register
//   that is applied only on a period boundary, a clean start/stop sequence,
//   and a shared sync input that restarts all running channels in phase.
//
// Ports
//   master_clk  in   1          clock, all logic on its rising edge
//   rst_n       in   1          asynchronous, active-low reset
//   div_ratio   in   NCH*DIV_W  channel i ratio at [i*DIV_W +: DIV_W]
//   load        in   NCH        pulse: capture channel ratio into shadow
//   ch_en       in   NCH        level: channel enable
//   sync        in   1          pulse: restart all running channels at phase 0
//   div_clk     out  NCH        divided clocks (registered)
//   div_pulse   out  NCH        1-cycle tick in each div_clk rising cycle
//   ratio_pend  out  NCH        shadow captured, not yet applied
//   ratio_err   out  NCH        sticky: last loaded ratio was <2, clamped to 2
//
// Channel FSM
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_OFF  | idle, cnt=0, div_clk=0; waits for ch_en
//   ST_RUN  | free-running divider
//   ST_STOP | enable dropped; finishes current period, then goes OFF
module clk_div_buff #(
  parameter int NCH   = 4,
  parameter int DIV_W = 8
) (
  input  logic                 master_clk,
  input  logic                 rst_n,
  input  logic [NCH*DIV_W-1:0] div_ratio,
  input  logic [NCH-1:0]       load,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 sync,
  output logic [NCH-1:0]       div_clk,
  output logic [NCH-1:0]       div_pulse,
  output logic [NCH-1:0]       ratio_pend,
  output logic [NCH-1:0]       ratio_err
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } ch_state_t;

  localparam logic [DIV_W-1:0] MIN_RATIO = DIV_W'(2);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_t        st_q, st_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             clk_q, clk_d;
    logic             pls_q, pls_d;
    logic [DIV_W-1:0] ld_raw;
    logic [DIV_W-1:0] ld_val;
    logic             ld_bad;
    logic             wrap;
    logic             sync_hit;

    assign ld_raw   = div_ratio[i*DIV_W +: DIV_W];
    assign ld_bad   = (ld_raw < MIN_RATIO);
    assign ld_val   = ld_bad ? MIN_RATIO : ld_raw;
    assign wrap     = (cnt_q == act_q - DIV_W'(1));
    // sync only affects channels that are already running
    assign sync_hit = sync && (st_q != ST_OFF);

    always_ff @(posedge master_clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= ST_OFF;
        cnt_q  <= '0;
        act_q  <= MIN_RATIO;
        shd_q  <= MIN_RATIO;
        pend_q <= 1'b0;
        err_q  <= 1'b0;
        clk_q  <= 1'b0;
        pls_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        err_q  <= err_d;
        clk_q  <= clk_d;
        pls_q  <= pls_d;
      end
    end

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      err_d  = err_q;
      clk_d  = 1'b0;
      pls_d  = 1'b0;

      if (st_q == ST_OFF) begin
        if (ch_en[i]) begin
          st_d   = ST_RUN;
          cnt_d  = '0;
          act_d  = shd_q;
          pend_d = 1'b0;
        end
      end else if (sync) begin
        // a load in the same cycle is taken straight into the active ratio
        st_d   = ch_en[i] ? ST_RUN : ST_STOP;
        cnt_d  = '0;
        act_d  = load[i] ? ld_val : shd_q;
        pend_d = 1'b0;
      end else if (wrap) begin
        // RUN with enable low at the boundary behaves like STOP reaching it
        st_d   = ch_en[i] ? ST_RUN : ST_OFF;
        cnt_d  = '0;
        act_d  = shd_q;
        pend_d = 1'b0;
      end else begin
        st_d   = ch_en[i] ? ST_RUN : ST_STOP;
        cnt_d  = cnt_q + DIV_W'(1);
      end

      // a load landing on an apply edge stays pending for the next boundary
      if (load[i]) begin
        shd_d = ld_val;
        err_d = ld_bad;
        if (!sync_hit) pend_d = 1'b1;
      end

      // outputs registered from the next count so they move with cnt
      if (st_d != ST_OFF) begin
        clk_d = (cnt_d < (act_d >> 1));
        pls_d = (cnt_d == '0);
      end
    end

    assign div_clk[i]    = clk_q;
    assign div_pulse[i]  = pls_q;
    assign ratio_pend[i] = pend_q;
    assign ratio_err[i]  = err_q;
  end

endmodule

// File: tb/tb_clk_div_buff.sv
module tb_clk_div_buff;
  localparam int NCH   = 4;
  localparam int DIV_W = 8;

  logic                 master_clk = 1'b0;
  logic                 rst_n      = 1'b0;
  logic [NCH*DIV_W-1:0] div_ratio  = '0;
  logic [NCH-1:0]       load       = '0;
  logic [NCH-1:0]       ch_en      = '0;
  logic                 sync       = 1'b0;
  logic [NCH-1:0]       div_clk, div_pulse, ratio_pend, ratio_err;

  always #5 master_clk = ~master_clk;

  clk_div_buff #(.NCH(NCH), .DIV_W(DIV_W)) dut (
    .master_clk (master_clk),
    .rst_n      (rst_n),
    .div_ratio  (div_ratio),
    .load       (load),
    .ch_en      (ch_en),
    .sync       (sync),
    .div_clk    (div_clk),
    .div_pulse  (div_pulse),
    .ratio_pend (ratio_pend),
    .ratio_err  (ratio_err)
  );

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] pls;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: each channel is described by when its current period
  // started (t0, in edge numbers) and how long that period is.
  bit m_on   [NCH];
  int m_t0   [NCH];
  int m_per  [NCH];
  int m_shd  [NCH];
  bit m_pend [NCH];
  bit m_err  [NCH];
  int k = 0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, want, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_on[i] = 0; m_t0[i] = 0; m_per[i] = 2; m_shd[i] = 2;
      m_pend[i] = 0; m_err[i] = 0;
    end
  endfunction

  // Outputs expected after edge number k, given the inputs now applied.
  function automatic exp_t model_step();
    exp_t e;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      int r, cr, prev, ph;
      bit used;
      r    = int'(div_ratio[i*DIV_W +: DIV_W]);
      cr   = (r < 2) ? 2 : r;
      prev = k - 1 - m_t0[i];
      used = 0;
      if (!m_on[i]) begin
        if (ch_en[i]) begin
          m_on[i] = 1; m_t0[i] = k; m_per[i] = m_shd[i]; m_pend[i] = 0;
        end
      end else if (sync) begin
        m_t0[i] = k;
        if (load[i]) begin m_shd[i] = cr; used = 1; end
        m_per[i] = m_shd[i]; m_pend[i] = 0;
      end else if (prev == m_per[i] - 1) begin
        m_t0[i] = k; m_per[i] = m_shd[i]; m_pend[i] = 0; m_on[i] = ch_en[i];
      end
      if (load[i] && !used) begin m_shd[i] = cr; m_pend[i] = 1; end
      if (load[i]) m_err[i] = (r < 2);
      ph = k - m_t0[i];
      e.clk[i]  = m_on[i] && (ph < m_per[i] / 2);
      e.pls[i]  = m_on[i] && (ph == 0);
      e.pend[i] = m_pend[i];
      e.err[i]  = m_err[i];
    end
    return e;
  endfunction

  task automatic set_ratio(input int ch, input int v);
    div_ratio[ch*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  // Called at posedge+2: queue expectation for the next edge, then advance.
  task automatic cycle();
    k++;
    exp_q.push_back(model_step());
    @(posedge master_clk);
    #2;
    load = '0;
    sync = 1'b0;
  endtask

  // Monitor: compares every cycle for which an expectation has been queued.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge master_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("div_clk",    div_clk,    e.clk);
        chk("div_pulse",  div_pulse,  e.pls);
        chk("ratio_pend", ratio_pend, e.pend);
        chk("ratio_err",  ratio_err,  e.err);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : driver
    int common, first_common, p0, p1, gap;
    model_reset();
    @(posedge master_clk);
    #2;
    chk("rst_div_clk",    div_clk,    0);
    chk("rst_div_pulse",  div_pulse,  0);
    chk("rst_ratio_pend", ratio_pend, 0);
    chk("rst_ratio_err",  ratio_err,  0);
    rst_n = 1'b1;

    // ch0 R=4, ch1 R=5 loaded while off, then started together
    set_ratio(0, 4); set_ratio(1, 5); load = 4'b0011;
    cycle();
    ch_en = 4'b0011;
    repeat (20) cycle();

    // ch2 loaded with 0: clamps to 2 and flags the error
    set_ratio(2, 0); load[2] = 1'b1; ch_en[2] = 1'b1;
    cycle();
    chk("ratio_err_ch2", ratio_err[2], 1);
    repeat (8) cycle();

    // sync with ch1 reload to 6: both rise together, LCM(4,6)=12
    set_ratio(1, 6); load[1] = 1'b1; sync = 1'b1;
    cycle();
    chk("sync_pulse_both", div_pulse[1:0], 2'b11);
    common = 0; first_common = 0; p0 = 0; p1 = 0;
    for (int j = 1; j <= 24; j++) begin
      cycle();
      if (div_pulse[0]) p0++;
      if (div_pulse[1]) p1++;
      if (div_pulse[0] && div_pulse[1]) begin
        common++;
        if (first_common == 0) first_common = j;
      end
    end
    chk("lcm_first_common", first_common, 12);
    chk("lcm_common_count", common, 2);
    chk("ch0_pulses_24",    p0, 6);
    chk("ch1_pulses_24",    p1, 4);

    // ch0 at cnt=1: load R=8, pending until the wrap, next period is 8
    cycle();
    set_ratio(0, 8); load[0] = 1'b1;
    cycle();
    chk("reload_pend_set", ratio_pend[0], 1);
    cycle();
    cycle();
    chk("reload_applied_pend", ratio_pend[0], 0);
    chk("reload_wrap_pulse",   div_pulse[0], 1);
    gap = 0;
    for (int j = 1; j <= 20 && gap == 0; j++) begin
      cycle();
      if (div_pulse[0]) gap = j;
    end
    chk("reload_new_period", gap, 8);

    // drop enable at cnt=1, re-enable at cnt=3 of STOP
    for (int g = 0; g < 20 && (k - m_t0[0]) != 1; g++) cycle();
    ch_en[0] = 1'b0;
    cycle();
    cycle();
    ch_en[0] = 1'b1;
    repeat (12) cycle();
    // full stop: completes the period then stays low
    ch_en[0] = 1'b0;
    repeat (14) cycle();
    chk("stopped_clk",   div_clk[0],   0);
    chk("stopped_pulse", div_pulse[0], 0);

    // async reset mid-high phase, with a pending ratio on ch3
    ch_en[0] = 1'b1;
    set_ratio(3, 7); load[3] = 1'b1;
    cycle();
    chk("pre_rst_clk0",  div_clk[0],    1);
    chk("pre_rst_pend3", ratio_pend[3], 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_div_clk",    div_clk,    0);
    chk("async_rst_div_pulse",  div_pulse,  0);
    chk("async_rst_ratio_pend", ratio_pend, 0);
    chk("async_rst_ratio_err",  ratio_err,  0);
    ch_en = '0;
    repeat (2) @(posedge master_clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    repeat (5) cycle();
    chk("post_rst_off", div_clk, 0);

    // randomized traffic
    ch_en = '1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 29) == 0) ch_en[i] = ~ch_en[i];
        if ($urandom_range(0, 11) == 0) begin
          set_ratio(i, int'($urandom_range(0, 12)));
          load[i] = 1'b1;
        end
      end
      sync = ($urandom_range(0, 39) == 0);
      cycle();
    end

    repeat (2) @(posedge master_clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
